cla_1_cell: RTL and testbench

- Parameterizable carry-lookahead adder slice; default configuration is a single-bit CLA cell.
- Produces sum, per-bit carry-out, generate and propagate terms; outputs are registered.
- Used as the leaf/slice element of wider lookahead adders on the summing board datapath; group G/P outputs let a higher lookahead level chain slices.

---
 rtl/cla_pkg.sv | 35 +++
 rtl/cla_bit.sv | 16 +
 rtl/cla_1_cell.sv | 87 ++++++++
 tb/tb_cla_1_cell.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared carry-lookahead definitions for the CLA slice and higher
// lookahead levels that chain slices through group G/P.
package cla_pkg;

    localparam int CLA_MAX_WIDTH = 64;

    // Bit i of the result is the carry out of bit i, each expanded as a
    // flat sum of products over g/p/c_in rather than a rippled chain.
    function automatic logic [CLA_MAX_WIDTH-1:0] cla_carry(
        input logic [CLA_MAX_WIDTH-1:0] g,
        input logic [CLA_MAX_WIDTH-1:0] p,
        input logic                     c_in,
        input int                       width
    );
        logic [CLA_MAX_WIDTH-1:0] c;
        logic                     term;
        c = '0;
        for (int i = 0; i < width; i++) begin
            term = c_in;
            for (int k = 0; k <= i; k++) begin
                term = term & p[k];
            end
            c[i] = term;
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int k = j + 1; k <= i; k++) begin
                    term = term & p[k];
                end
                c[i] = c[i] | term;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/cla_bit.sv
// Single-bit leaf of the lookahead adder: generate/propagate from the
// addends and the sum bit from propagate and the incoming carry.
module cla_bit (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic g,
    output logic p,
    output logic s
);

    assign g = a & b;
    assign p = a ^ b;
    assign s = p ^ c;

endmodule

// File: rtl/cla_1_cell.sv
// Registered carry-lookahead adder slice with per-bit carries and
// group generate/propagate for chaining into a wider lookahead tree.
module cla_1_cell
    import cla_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] c_out,
    output logic [WIDTH-1:0] g,
    output logic [WIDTH-1:0] p,
    output logic             gg,
    output logic             gp
);

    logic [WIDTH-1:0]         g_w;
    logic [WIDTH-1:0]         p_w;
    logic [WIDTH-1:0]         s_w;
    logic [WIDTH-1:0]         c_bit;
    logic [CLA_MAX_WIDTH-1:0] g_ext;
    logic [CLA_MAX_WIDTH-1:0] p_ext;
    logic [CLA_MAX_WIDTH-1:0] carry_full;
    logic [CLA_MAX_WIDTH-1:0] carry_gen;
    logic                     unused_carry;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        cla_bit u_bit (
            .a (a[i]),
            .b (b[i]),
            .c (c_bit[i]),
            .g (g_w[i]),
            .p (p_w[i]),
            .s (s_w[i])
        );
    end

    always_comb begin
        g_ext = '0;
        p_ext = '0;
        g_ext[WIDTH-1:0] = g_w;
        p_ext[WIDTH-1:0] = p_w;
    end

    // Group generate is the same network evaluated with no carry in.
    assign carry_full = cla_carry(g_ext, p_ext, c_in, WIDTH);
    assign carry_gen  = cla_carry(g_ext, p_ext, 1'b0, WIDTH);

    assign unused_carry = ^{carry_full, carry_gen};

    always_comb begin
        c_bit    = '0;
        c_bit[0] = c_in;
        for (int i = 1; i < WIDTH; i++) begin
            c_bit[i] = carry_full[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            s         <= '0;
            c_out     <= '0;
            g         <= '0;
            p         <= '0;
            gg        <= 1'b0;
            gp        <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                s     <= s_w;
                c_out <= carry_full[WIDTH-1:0];
                g     <= g_w;
                p     <= p_w;
                gg    <= carry_gen[WIDTH-1];
                gp    <= &p_w;
            end
        end
    end

endmodule

// File: tb/tb_cla_1_cell.sv
// Randomized and directed checks of the 1-bit and 4-bit CLA slice
// against an arithmetic reference model.
module tb_cla_1_cell;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       c_in;
    logic       a1;
    logic       b1;
    logic [3:0] a4;
    logic [3:0] b4;

    logic       ov1;
    logic       s1;
    logic       co1;
    logic       g1;
    logic       p1;
    logic       gg1;
    logic       gp1;

    logic       ov4;
    logic [3:0] s4;
    logic [3:0] co4;
    logic [3:0] g4;
    logic [3:0] p4;
    logic       gg4;
    logic       gp4;

    int n_cmp;
    int n_bad;

    logic [63:0] e1_s, e1_co, e1_g, e1_p;
    logic        e1_ov, e1_gg, e1_gp;
    logic [63:0] e4_s, e4_co, e4_g, e4_p;
    logic        e4_ov, e4_gg, e4_gp;

    cla_1_cell u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a1),
        .b         (b1),
        .c_in      (c_in),
        .out_valid (ov1),
        .s         (s1),
        .c_out     (co1),
        .g         (g1),
        .p         (p1),
        .gg        (gg1),
        .gp        (gp1)
    );

    cla_1_cell #(.WIDTH(4)) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a4),
        .b         (b4),
        .c_in      (c_in),
        .out_valid (ov4),
        .s         (s4),
        .c_out     (co4),
        .g         (g4),
        .p         (p4),
        .gg        (gg4),
        .gp        (gp4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer addition; carry out of bit i is the
    // overflow of the low i+1 bits of a+b+c_in.
    task automatic ref_add(input int w, input logic [63:0] a,
                           input logic [63:0] b, input logic ci,
                           output logic [63:0] s, output logic [63:0] co,
                           output logic [63:0] g, output logic [63:0] p,
                           output logic gg, output logic gp);
        logic [63:0] mask;
        logic [63:0] m;
        logic [63:0] sum;
        mask = (64'd1 << w) - 64'd1;
        sum  = (a & mask) + (b & mask) + 64'(ci);
        s    = sum & mask;
        g    = a & b & mask;
        p    = (a ^ b) & mask;
        co   = '0;
        for (int i = 0; i < w; i++) begin
            m = (64'd1 << (i + 1)) - 64'd1;
            sum = (a & m) + (b & m) + 64'(ci);
            co[i] = sum[i+1];
        end
        sum = (a & mask) + (b & mask);
        gg  = sum[w];
        gp  = (p == mask);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            {e1_s, e1_co, e1_g, e1_p} = '0;
            {e4_s, e4_co, e4_g, e4_p} = '0;
            {e1_ov, e1_gg, e1_gp} = '0;
            {e4_ov, e4_gg, e4_gp} = '0;
        end else begin
            e1_ov = in_valid;
            e4_ov = in_valid;
            if (in_valid) begin
                ref_add(1, 64'(a1), 64'(b1), c_in,
                        e1_s, e1_co, e1_g, e1_p, e1_gg, e1_gp);
                ref_add(4, 64'(a4), 64'(b4), c_in,
                        e4_s, e4_co, e4_g, e4_p, e4_gg, e4_gp);
            end
        end
        #1;
        chk("w1 out_valid", 64'(ov1), 64'(e1_ov));
        chk("w1 s",         64'(s1),  e1_s);
        chk("w1 c_out",     64'(co1), e1_co);
        chk("w1 g",         64'(g1),  e1_g);
        chk("w1 p",         64'(p1),  e1_p);
        chk("w1 gg",        64'(gg1), 64'(e1_gg));
        chk("w1 gp",        64'(gp1), 64'(e1_gp));
        chk("w4 out_valid", 64'(ov4), 64'(e4_ov));
        chk("w4 s",         64'(s4),  e4_s);
        chk("w4 c_out",     64'(co4), e4_co);
        chk("w4 g",         64'(g4),  e4_g);
        chk("w4 p",         64'(p4),  e4_p);
        chk("w4 gg",        64'(gg4), 64'(e4_gg));
        chk("w4 gp",        64'(gp4), 64'(e4_gp));
    endtask

    task automatic drive(input logic v, input logic [3:0] a,
                         input logic [3:0] b, input logic ci);
        in_valid = v;
        a4 = a;
        b4 = b;
        a1 = a[0];
        b1 = b[0];
        c_in = ci;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        drive(1'b1, 4'd1, 4'd1, 1'b0);
        tick();
        tick();
        chk("reset s4 zero", 64'(s4), 64'd0);
        chk("reset ov1 zero", 64'(ov1), 64'd0);
        rst = 1'b0;

        drive(1'b1, 4'd0, 4'd0, 1'b0); tick();
        drive(1'b1, 4'd0, 4'd1, 1'b1); tick();
        chk("w1 0+1+1 c_out", 64'(co1), 64'd1);
        drive(1'b1, 4'd1, 4'd1, 1'b0); tick();
        chk("w1 1+1 gg", 64'(gg1), 64'd1);
        drive(1'b1, 4'd1, 4'd1, 1'b1); tick();
        drive(1'b0, 4'd0, 4'd0, 1'b0); tick();
        tick();
        drive(1'b1, 4'd7, 4'd9, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b1, 4'hF, 4'h0, 1'b1); tick();
        chk("w4 F+0+1 c_out", 64'(co4), 64'hF);
        chk("w4 F+0+1 s", 64'(s4), 64'h0);

        for (int ci = 0; ci < 2; ci++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    drive(1'b1, 4'(a), 4'(b), 1'(ci));
                    tick();
                end
            end
        end

        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 31) == 0);
            drive(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            tick();
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
